dram_uart_tx: RTL and testbench
===============================

DRAM_UART_TX -- requirements
Module: dram_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 Parameter BYTE_COUNT, default 16384, number of bytes sent per transfer (downsampled 128x128 image); legal range 1..65536.
REQ-003 Parameter START_ADDR, default 16'h0000, first DRAM address read.
REQ-004 clock  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start_Tx  input  1  level from processor; a 0->1 transition requests a transfer.
REQ-007 DRAM_input_data  input  8  DRAM read data; valid one cycle after DRAM_address_tx changes.
REQ-008 DRAM_address_tx  output  16  DRAM read address, registered.
REQ-009 tx_serial  output  1  UART line, 8N1, idle high, registered.
REQ-010 tx_busy  output  1  high from transfer acceptance until the tx_done cycle, inclusive.
REQ-011 tx_done  output  1  one-cycle pulse after the last stop bit of a transfer.

Function
REQ-012 States SHALL be IDLE, FETCH, LOAD, START_BIT, DATA_BITS, STOP_BIT, NEXT, DONE.
REQ-013 start_Tx SHALL be registered once; a request is a cycle where start_Tx=1 and its registered value=0.
REQ-014 IDLE: on a request, next state FETCH, DRAM_address_tx<=START_ADDR, byte counter<=0, tx_busy<=1.
REQ-015 Requests outside IDLE SHALL be ignored; start_Tx held high SHALL NOT retrigger; a new transfer needs start_Tx to fall and rise again.
REQ-016 FETCH: one wait cycle for DRAM read latency, then LOAD.
REQ-017 LOAD: DRAM_input_data SHALL be captured into an 8-bit shift register; next START_BIT.
REQ-018 START_BIT: tx_serial=0 for exactly CLKS_PER_BIT cycles.
REQ-019 DATA_BITS: 8 bits LSB first, each held exactly CLKS_PER_BIT cycles; 3-bit bit index wraps 7->0 on exit.
REQ-020 STOP_BIT: tx_serial=1 for exactly CLKS_PER_BIT cycles.
REQ-021 NEXT: if byte counter = BYTE_COUNT-1, go DONE; else counter+1, DRAM_address_tx+1, go FETCH.
REQ-022 Byte period SHALL be exactly 10*CLKS_PER_BIT+3 cycles (FETCH, LOAD, NEXT overhead); tx_serial=1 in FETCH, LOAD, NEXT.
REQ-023 Address SHALL wrap 16'hFFFF->16'h0000 without error; byte counter is 17 bits so BYTE_COUNT=65536 is exact.
REQ-024 DONE: tx_done=1 and tx_busy=1 for one cycle, then IDLE with tx_busy=0.
REQ-025 A request seen in the DONE cycle SHALL be ignored.
REQ-026 Baud counter SHALL reload to 0 at each bit boundary; no cumulative drift.
REQ-027 tx_serial SHALL be glitch-free (flop output); changes only at bit boundaries.

Reset
REQ-028 Reset SHALL force state IDLE, tx_serial=1, tx_busy=0, tx_done=0, DRAM_address_tx=START_ADDR, counters 0, shift register 0, start_Tx edge flop 0.
REQ-029 Reset mid-frame SHALL abort; tx_serial=1 from the cycle after reset is sampled; no partial byte resumes.
REQ-030 If start_Tx is high when reset deasserts, the edge flop SHALL capture it on the first post-reset cycle and no transfer SHALL start until start_Tx falls and rises.

Verification (CLKS_PER_BIT=4, BYTE_COUNT=3, START_ADDR=0, DRAM[0..2]=A5,3C,FF, 1-cycle DRAM model)
REQ-031 Single transfer: start_Tx 0->1 -> tx_serial decodes 0xA5,0x3C,0xFF; each frame start low 4 cycles, stop high 4 cycles; frame-start spacing 43 cycles; tx_done one pulse; tx_busy low after.
REQ-032 Bit timing: 0xA5 -> line after start bit reads 1,0,1,0,0,1,0,1 (LSB first), each exactly 4 cycles.
REQ-033 Retrigger: start_Tx held high 200 cycles, then second 0->1 during busy -> exactly 3 bytes, one tx_done; third edge after tx_done -> second full transfer of 3 bytes.
REQ-034 Reset mid-operation: reset at bit 3 of byte 1 -> next cycle tx_serial=1, tx_busy=0, DRAM_address_tx=0; fresh start_Tx edge resends from 0xA5.
REQ-035 Wrap: START_ADDR=16'hFFFF, BYTE_COUNT=2 -> reads addresses FFFF then 0000, two bytes, one tx_done.
REQ-036 Reset release with start_Tx=1 -> no transfer, tx_serial stays 1 until start_Tx toggles 0->1.

Source files
------------

// File: rtl/dram_uart_tx_if.sv
// Handshake and DRAM read bus for the DRAM-to-UART streamer.
// master is the streamer side; slave is the processor/DRAM/line side.
interface dram_uart_tx_if;
  logic        start_Tx;
  logic [7:0]  DRAM_input_data;
  logic [15:0] DRAM_address_tx;
  logic        tx_serial;
  logic        tx_busy;
  logic        tx_done;

  modport master (
    input  start_Tx,
    input  DRAM_input_data,
    output DRAM_address_tx,
    output tx_serial,
    output tx_busy,
    output tx_done
  );

  modport slave (
    output start_Tx,
    output DRAM_input_data,
    input  DRAM_address_tx,
    input  tx_serial,
    input  tx_busy,
    input  tx_done
  );
endinterface

// File: rtl/dram_uart_tx.sv
// Streams BYTE_COUNT bytes from DRAM, starting at START_ADDR, out of an 8N1 UART line.
// Every output is a flop; the next-state logic also computes next-cycle line level.
module dram_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned BYTE_COUNT   = 16384,
  parameter logic [15:0] START_ADDR   = 16'h0000
) (
  input logic            i_clock,
  input logic            i_reset,
  dram_uart_tx_if.master io_bus
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StStartBit,
    StDataBits,
    StStopBit,
    StNext,
    StDone
  } state_e;

  localparam logic [15:0] BaudLast = 16'(CLKS_PER_BIT - 1);
  localparam logic [16:0] CntLast  = 17'(BYTE_COUNT - 1);

  state_e      r_state, w_state_d;
  logic        r_start_q;
  logic        r_rst_q;
  logic [15:0] r_addr, w_addr_d;
  logic [16:0] r_cnt, w_cnt_d;
  logic [15:0] r_baud, w_baud_d;
  logic [2:0]  r_bit, w_bit_d;
  logic [7:0]  r_shift, w_shift_d;
  logic        r_serial, w_serial_d;
  logic        r_busy;
  logic        r_done;
  logic        w_request;
  logic        w_baud_tick;

  // r_rst_q masks the first post-reset cycle, so a start_Tx already high at release is
  // only captured by the edge flop and never taken as a request.
  assign w_request   = io_bus.start_Tx & ~r_start_q & ~r_rst_q;
  assign w_baud_tick = (r_baud == BaudLast);

  always_comb begin
    w_state_d  = r_state;
    w_addr_d   = r_addr;
    w_cnt_d    = r_cnt;
    w_baud_d   = r_baud;
    w_bit_d    = r_bit;
    w_shift_d  = r_shift;
    w_serial_d = 1'b1;

    unique case (r_state)
      StIdle: begin
        if (w_request) begin
          w_state_d = StFetch;
          w_addr_d  = START_ADDR;
          w_cnt_d   = '0;
        end
      end
      StFetch: w_state_d = StLoad;
      StLoad: begin
        w_shift_d = io_bus.DRAM_input_data;
        w_baud_d  = '0;
        w_state_d = StStartBit;
      end
      StStartBit: begin
        if (w_baud_tick) begin
          w_baud_d  = '0;
          w_bit_d   = '0;
          w_state_d = StDataBits;
        end else begin
          w_baud_d = r_baud + 16'd1;
        end
      end
      StDataBits: begin
        if (w_baud_tick) begin
          w_baud_d  = '0;
          w_shift_d = {1'b0, r_shift[7:1]};
          w_bit_d   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_d = StStopBit;
        end else begin
          w_baud_d = r_baud + 16'd1;
        end
      end
      StStopBit: begin
        if (w_baud_tick) begin
          w_baud_d  = '0;
          w_state_d = StNext;
        end else begin
          w_baud_d = r_baud + 16'd1;
        end
      end
      StNext: begin
        if (r_cnt == CntLast) begin
          w_state_d = StDone;
        end else begin
          w_cnt_d   = r_cnt + 17'd1;
          w_addr_d  = r_addr + 16'd1;
          w_state_d = StFetch;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase

    // Line level follows the state being entered, so the flop lines up with that state.
    case (w_state_d)
      StStartBit: w_serial_d = 1'b0;
      StDataBits: w_serial_d = w_shift_d[0];
      default:    w_serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clock) begin
    r_rst_q <= i_reset;
    if (i_reset) begin
      r_state   <= StIdle;
      r_start_q <= 1'b0;
      r_addr    <= START_ADDR;
      r_cnt     <= '0;
      r_baud    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_serial  <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_start_q <= io_bus.start_Tx;
      r_addr    <= w_addr_d;
      r_cnt     <= w_cnt_d;
      r_baud    <= w_baud_d;
      r_bit     <= w_bit_d;
      r_shift   <= w_shift_d;
      r_serial  <= w_serial_d;
      r_busy    <= (w_state_d != StIdle);
      r_done    <= (w_state_d == StDone);
    end
  end

  assign io_bus.DRAM_address_tx = r_addr;
  assign io_bus.tx_serial       = r_serial;
  assign io_bus.tx_busy         = r_busy;
  assign io_bus.tx_done         = r_done;

endmodule

// File: tb/tb_dram_uart_tx.sv
// Bench for dram_uart_tx: traces are captured per cycle and compared against a frame
// model built from the byte period; a vector table pins the first 0xA5 frame.
module tb_dram_uart_tx;
  localparam int Cpb   = 4;
  localparam int Bp    = 10 * Cpb + 3;
  localparam int TrMax = 256;
  localparam int NVec  = 19;

  typedef struct {
    int   cyc;
    logic ser;
    logic busy;
    logic done;
  } vec_t;

  logic        clk;
  logic        rst;
  int          checks;
  int          errors;
  int          bad;
  logic [7:0]  mem     [0:65535];
  logic        tr_ser  [TrMax];
  logic        tr_busy [TrMax];
  logic        tr_done [TrMax];
  logic [15:0] tr_addr [TrMax];
  vec_t        tbl     [NVec];

  dram_uart_tx_if u_if_a ();
  dram_uart_tx_if u_if_b ();

  dram_uart_tx #(
    .CLKS_PER_BIT(Cpb),
    .BYTE_COUNT  (3),
    .START_ADDR  (16'h0000)
  ) u_dut_a (
    .i_clock(clk),
    .i_reset(rst),
    .io_bus (u_if_a)
  );

  dram_uart_tx #(
    .CLKS_PER_BIT(Cpb),
    .BYTE_COUNT  (2),
    .START_ADDR  (16'hFFFF)
  ) u_dut_b (
    .i_clock(clk),
    .i_reset(rst),
    .io_bus (u_if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency DRAM shared by both instances.
  always @(posedge clk) begin
    u_if_a.DRAM_input_data <= mem[u_if_a.DRAM_address_tx];
    u_if_b.DRAM_input_data <= mem[u_if_b.DRAM_address_tx];
  end

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic request(input bit sel_b);
    @(posedge clk); #1;
    if (sel_b) u_if_b.start_Tx = 1'b0;
    else       u_if_a.start_Tx = 1'b0;
    @(posedge clk); #1;
    if (sel_b) u_if_b.start_Tx = 1'b1;
    else       u_if_a.start_Tx = 1'b1;
  endtask

  // Trace index 0 is the first cycle after the request edge.
  task automatic capture(input bit sel_b, input int n, input int toggle_at);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (sel_b) begin
        tr_ser[c]  = u_if_b.tx_serial;
        tr_busy[c] = u_if_b.tx_busy;
        tr_done[c] = u_if_b.tx_done;
        tr_addr[c] = u_if_b.DRAM_address_tx;
      end else begin
        tr_ser[c]  = u_if_a.tx_serial;
        tr_busy[c] = u_if_a.tx_busy;
        tr_done[c] = u_if_a.tx_done;
        tr_addr[c] = u_if_a.DRAM_address_tx;
      end
      if (c == toggle_at)     u_if_a.start_Tx = 1'b0;
      if (c == toggle_at + 2) u_if_a.start_Tx = 1'b1;
    end
  endtask

  // Each byte: 2 idle-high cycles, start, 8 data LSB first, stop, 1 idle-high; then DONE.
  task automatic check_model(input string name, input int nbytes, input logic [15:0] base,
                             input int n);
    int          total;
    int          k;
    int          off;
    logic [15:0] a;
    logic [7:0]  b;
    logic        e_ser;
    total = nbytes * Bp;
    for (int c = 0; c < n; c++) begin
      e_ser = 1'b1;
      if (c < total) begin
        k   = c / Bp;
        off = c % Bp;
        a   = base + 16'(k);
        b   = mem[a];
        if (off >= 2 && off < 2 + Cpb) e_ser = 1'b0;
        else if (off >= 2 + Cpb && off < 2 + 9 * Cpb) e_ser = b[(off - 2 - Cpb) / Cpb];
        if (off == 0) check1($sformatf("%s c%0d addr", name, c), 32'(tr_addr[c]), 32'(a));
      end
      check1($sformatf("%s c%0d serial", name, c), 32'(tr_ser[c]), 32'(e_ser));
      check1($sformatf("%s c%0d busy", name, c), 32'(tr_busy[c]), 32'(c <= total));
      check1($sformatf("%s c%0d done", name, c), 32'(tr_done[c]), 32'(c == total));
    end
  endtask

  task automatic hold_idle(input int n);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (u_if_a.tx_busy !== 1'b0 || u_if_a.tx_serial !== 1'b1 || u_if_a.tx_done !== 1'b0)
        bad++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    u_if_a.start_Tx = 1'b0;
    u_if_b.start_Tx = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[0] = 8'hA5;
    mem[1] = 8'h3C;
    mem[2] = 8'hFF;

    tbl[0]  = '{0,   1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1,   1'b1, 1'b1, 1'b0};
    tbl[2]  = '{2,   1'b0, 1'b1, 1'b0};
    tbl[3]  = '{5,   1'b0, 1'b1, 1'b0};
    tbl[4]  = '{6,   1'b1, 1'b1, 1'b0};
    tbl[5]  = '{9,   1'b1, 1'b1, 1'b0};
    tbl[6]  = '{10,  1'b0, 1'b1, 1'b0};
    tbl[7]  = '{14,  1'b1, 1'b1, 1'b0};
    tbl[8]  = '{18,  1'b0, 1'b1, 1'b0};
    tbl[9]  = '{22,  1'b0, 1'b1, 1'b0};
    tbl[10] = '{26,  1'b1, 1'b1, 1'b0};
    tbl[11] = '{30,  1'b0, 1'b1, 1'b0};
    tbl[12] = '{34,  1'b1, 1'b1, 1'b0};
    tbl[13] = '{38,  1'b1, 1'b1, 1'b0};
    tbl[14] = '{42,  1'b1, 1'b1, 1'b0};
    tbl[15] = '{45,  1'b0, 1'b1, 1'b0};
    tbl[16] = '{88,  1'b0, 1'b1, 1'b0};
    tbl[17] = '{129, 1'b1, 1'b1, 1'b1};
    tbl[18] = '{130, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check1("rst a serial", 32'(u_if_a.tx_serial), 32'd1);
    check1("rst a busy", 32'(u_if_a.tx_busy), 32'd0);
    check1("rst a done", 32'(u_if_a.tx_done), 32'd0);
    check1("rst a addr", 32'(u_if_a.DRAM_address_tx), 32'h0000);
    check1("rst b addr", 32'(u_if_b.DRAM_address_tx), 32'hFFFF);
    check1("rst b serial", 32'(u_if_b.tx_serial), 32'd1);
    rst = 1'b0;

    // Single transfer of A5,3C,FF
    request(1'b0);
    capture(1'b0, 140, -1);
    for (int i = 0; i < NVec; i++) begin
      check1($sformatf("vec%0d serial", i), 32'(tr_ser[tbl[i].cyc]), 32'(tbl[i].ser));
      check1($sformatf("vec%0d busy", i), 32'(tr_busy[tbl[i].cyc]), 32'(tbl[i].busy));
      check1($sformatf("vec%0d done", i), 32'(tr_done[tbl[i].cyc]), 32'(tbl[i].done));
    end
    check_model("xfer1", 3, 16'h0000, 140);

    // start_Tx still high: ~200 cycles held must not retrigger
    hold_idle(60);
    check1("held high retrigger", 32'(bad), 32'd0);

    // Random data; first run gets a second edge mid-transfer, next ones are fresh edges
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 3; i++) mem[i] = 8'($urandom);
      repeat ($urandom_range(1, 8)) @(posedge clk);
      request(1'b0);
      capture(1'b0, 180, (t == 0) ? 50 : -1);
      check_model($sformatf("rand%0d", t), 3, 16'h0000, 180);
    end

    // Reset at bit 3 of byte 1, start_Tx left high through release
    mem[0] = 8'hA5;
    mem[1] = 8'h3C;
    mem[2] = 8'hFF;
    request(1'b0);
    capture(1'b0, 62, -1);
    check1("pre-rst busy", 32'(tr_busy[61]), 32'd1);
    check1("pre-rst bit3", 32'(tr_ser[61]), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check1("mid-rst serial", 32'(u_if_a.tx_serial), 32'd1);
    check1("mid-rst busy", 32'(u_if_a.tx_busy), 32'd0);
    check1("mid-rst addr", 32'(u_if_a.DRAM_address_tx), 32'h0000);
    check1("mid-rst done", 32'(u_if_a.tx_done), 32'd0);
    rst = 1'b0;
    hold_idle(50);
    check1("release high no start", 32'(bad), 32'd0);
    request(1'b0);
    capture(1'b0, 140, -1);
    check_model("after-rst", 3, 16'h0000, 140);

    // Address wrap FFFF -> 0000 on the second instance
    mem[16'hFFFF] = 8'($urandom);
    mem[16'h0000] = 8'($urandom);
    request(1'b1);
    capture(1'b1, 100, -1);
    check_model("wrap", 2, 16'hFFFF, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
